// File: rtl/mcu_spi_slave_pkg.sv
// Shared types and defaults for the MCU SPI slave: FSM state encoding and parameter defaults.
package mcu_spi_slave_pkg;

  localparam int DEF_SYNC_STAGES    = 3;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_PARAM = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  // Byte counter never wraps; it parks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mcu_spi_slave_if.sv
// SPI pin and command-decoder signal bundle; slave modport is the FPGA side, master the MCU/decoder side.
interface mcu_spi_slave_if;

  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_ssel_n;
  logic        spi_miso;
  logic [7:0]  data_in;
  logic        cmd_ready;
  logic        param_ready;
  logic [7:0]  cmd_data;
  logic [7:0]  param_data;
  logic [31:0] byte_cnt;
  logic [2:0]  bit_cnt;
  logic        frame_active;
  logic        frame_err;

  modport slave (
    input  spi_sck, spi_mosi, spi_ssel_n, data_in,
    output spi_miso, cmd_ready, param_ready, cmd_data, param_data,
           byte_cnt, bit_cnt, frame_active, frame_err
  );

  modport master (
    output spi_sck, spi_mosi, spi_ssel_n, data_in,
    input  spi_miso, cmd_ready, param_ready, cmd_data, param_data,
           byte_cnt, bit_cnt, frame_active, frame_err
  );

endinterface

// File: rtl/mcu_spi_slave_sync_edge.sv
// STAGES-deep synchroniser for one async pin plus rise/fall pulses on the synced level.
// Level appears STAGES clk after the pin; edge pulses last exactly one clk.
module mcu_spi_slave_sync_edge #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcu_spi_slave.sv
// MCU SPI slave (mode 0, MSB first): deframes command/parameter bytes and shifts decoder replies onto MISO.
// Strobes fire 1 clk after the synced 8th SCK rise; no backpressure. MCU_SPI_TIMEOUT_EN adds a stall abort.
module mcu_spi_slave
  import mcu_spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic            clk,
  input logic            rst,
  mcu_spi_slave_if.slave bus
);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic ssel_s, ssel_rise, ssel_fall;

  mcu_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din_i(bus.spi_sck),
    .sync_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  mcu_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din_i(bus.spi_mosi),
    .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  // SSEL idles high so reset never fabricates a frame start.
  mcu_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
    .clk(clk), .rst(rst), .din_i(bus.spi_ssel_n),
    .sync_o(ssel_s), .rise_o(ssel_rise), .fall_o(ssel_fall)
  );

  state_e      state_q, state_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, cmd_q, cmd_d, par_q, par_d;
  logic [2:0]  bit_q, bit_d;
  logic [31:0] byte_q, byte_d;
  logic        miso_q, miso_d, cmd_rdy_q, cmd_rdy_d, par_rdy_q, par_rdy_d;
  logic [7:0]  rx_next;

  assign rx_next = {rx_q[6:0], mosi_s};

`ifdef MCU_SPI_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        tmo_hit;

  assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_d = tmo_q;
    if (sck_rise || sck_fall || ssel_fall) begin
      tmo_d = '0;
    end else if (!ssel_s && !tmo_hit) begin
      tmo_d = tmo_q + 32'd1;
    end
  end
`else
  localparam int TimeoutUnused = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    par_d     = par_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    miso_d    = miso_q;
    cmd_rdy_d = 1'b0;
    par_rdy_d = 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ssel_fall) begin
          state_d = ST_CMD;
          rx_d    = '0;
          tx_d    = '0;
          bit_d   = '0;
          byte_d  = '0;
          miso_d  = 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_CMD, ST_PARAM: begin
        if (sck_rise) begin
          rx_d  = rx_next;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_d = sat_inc(byte_q);
            if (state_q == ST_CMD) begin
              cmd_d     = rx_next;
              cmd_rdy_d = 1'b1;
              state_d   = ST_PARAM;
            end else begin
              par_d     = rx_next;
              par_rdy_d = 1'b1;
            end
          end
        end
        // Reply is loaded on the first falling edge after a byte boundary; tx_q is zero during the command byte.
        if (sck_fall) begin
          if (bit_q != 3'd0) begin
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
          end else if (byte_q != 32'd0) begin
            tx_d   = bus.data_in;
            miso_d = bus.data_in[7];
          end
        end
`ifdef MCU_SPI_TIMEOUT_EN
        if (tmo_hit) begin
          state_d = ST_ABORT;
          bit_d   = '0;
          err_d   = 1'b1;
        end
`endif
        if (ssel_rise) begin
          state_d = ST_IDLE;
          bit_d   = '0;
        end
      end
`ifdef MCU_SPI_TIMEOUT_EN
      ST_ABORT: begin
        if (ssel_rise) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_q     <= '0;
      par_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      miso_q    <= 1'b0;
      cmd_rdy_q <= 1'b0;
      par_rdy_q <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cmd_q     <= cmd_d;
      par_q     <= par_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      miso_q    <= miso_d;
      cmd_rdy_q <= cmd_rdy_d;
      par_rdy_q <= par_rdy_d;
`ifdef MCU_SPI_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.spi_miso     = miso_q;
  assign bus.cmd_ready    = cmd_rdy_q;
  assign bus.param_ready  = par_rdy_q;
  assign bus.cmd_data     = cmd_q;
  assign bus.param_data   = par_q;
  assign bus.byte_cnt     = byte_q;
  assign bus.bit_cnt      = bit_q;
  assign bus.frame_active = ~ssel_s;
`ifdef MCU_SPI_TIMEOUT_EN
  assign bus.frame_err    = err_q;
`else
  assign bus.frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Scoreboard bench for mcu_spi_slave: stimulus pushes expected strobes, MISO bytes and level probes;
// a single negedge monitor pops and compares them.
module tb_mcu_spi_slave;

  localparam int HALF = 8;
`ifdef MCU_SPI_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65535;
`endif

  localparam logic [3:0] S_CMD_RDY = 4'd0, S_PAR_RDY = 4'd1, S_CMD_DAT = 4'd2, S_PAR_DAT = 4'd3,
                         S_BYTE = 4'd4, S_BIT = 4'd5, S_ACT = 4'd6, S_ERR = 4'd7, S_MISO = 4'd8;

  typedef struct packed {
    logic        is_cmd;
    logic [7:0]  dat;
    logic [31:0] cnt;
  } strobe_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] exp;
  } probe_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mcu_spi_slave_if bus();

  mcu_spi_slave #(.SYNC_STAGES(3), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  strobe_t    exp_q[$];
  logic [7:0] miso_q[$];
  probe_t     probe_q[$];
  int         errors = 0;
  int         checks = 0;
  logic       in_frame = 1'b0;
  logic       done = 1'b0;
  int         bidx = 0;

  function automatic string sig_name(input logic [3:0] s);
    case (s)
      S_CMD_RDY: return "cmd_ready";
      S_PAR_RDY: return "param_ready";
      S_CMD_DAT: return "cmd_data";
      S_PAR_DAT: return "param_data";
      S_BYTE:    return "byte_cnt";
      S_BIT:     return "bit_cnt";
      S_ACT:     return "frame_active";
      S_ERR:     return "frame_err";
      default:   return "spi_miso";
    endcase
  endfunction

  function automatic logic [31:0] sig_val(input logic [3:0] s);
    case (s)
      S_CMD_RDY: return 32'(bus.cmd_ready);
      S_PAR_RDY: return 32'(bus.param_ready);
      S_CMD_DAT: return 32'(bus.cmd_data);
      S_PAR_DAT: return 32'(bus.param_data);
      S_BYTE:    return bus.byte_cnt;
      S_BIT:     return 32'(bus.bit_cnt);
      S_ACT:     return 32'(bus.frame_active);
      S_ERR:     return 32'(bus.frame_err);
      default:   return 32'(bus.spi_miso);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the only process that compares and counts.
  initial begin : monitor
    strobe_t    e;
    probe_t     p;
    logic [7:0] m;
    logic       sck_prev;
    logic       ssel_prev;
    logic [7:0] mbyte;
    int         mbits;
    sck_prev = 1'b0; ssel_prev = 1'b1; mbyte = '0; mbits = 0;
    forever begin
      @(negedge clk);
      while (probe_q.size() != 0) begin
        p = probe_q.pop_front();
        check(sig_name(p.sel), sig_val(p.sel), p.exp);
      end
      if (!rst && (bus.cmd_ready || bus.param_ready)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got cmd_ready=%0b param_ready=%0b required none",
                   bus.cmd_ready, bus.param_ready);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", 32'({bus.cmd_ready, bus.param_ready}), e.is_cmd ? 32'd2 : 32'd1);
          check("strobe_data", e.is_cmd ? 32'(bus.cmd_data) : 32'(bus.param_data), 32'(e.dat));
          check("strobe_byte_cnt", bus.byte_cnt, e.cnt);
        end
      end
      if (!bus.spi_ssel_n && ssel_prev) mbits = 0;
      if (in_frame && bus.spi_sck && !sck_prev) begin
        mbyte = {mbyte[6:0], bus.spi_miso};
        mbits++;
        if (mbits == 8) begin
          mbits = 0;
          if (miso_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_miso_byte: got %0h required none", mbyte);
          end else begin
            m = miso_q.pop_front();
            check("miso_byte", 32'(mbyte), 32'(m));
          end
        end
      end
      sck_prev  = bus.spi_sck;
      ssel_prev = bus.spi_ssel_n;
      if (done) begin
        check("strobe_queue_left", 32'(exp_q.size()), 32'd0);
        check("miso_queue_left", 32'(miso_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [3:0] sel, input logic [31:0] exp);
    probe_t p;
    p.sel = sel;
    p.exp = exp;
    probe_q.push_back(p);
  endtask

  task automatic probe_all_zero();
    for (int s = 0; s <= 8; s++) probe(4'(s), 32'd0);
  endtask

  task automatic clk_bit(input logic b, input logic rise_ends_frame);
    bus.spi_mosi = b;
    tick(HALF);
    bus.spi_sck = 1'b1;
    if (rise_ends_frame) bus.spi_ssel_n = 1'b1;
    tick(HALF);
    bus.spi_sck = 1'b0;
  endtask

  task automatic frame_begin();
    bidx            = 0;
    in_frame        = 1'b1;
    bus.spi_ssel_n  = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_end();
    tick(HALF);
    bus.spi_ssel_n = 1'b1;
    tick(2 * HALF);
    in_frame = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last_coincident);
    strobe_t s;
    bidx++;
    s.is_cmd = (bidx == 1);
    s.dat    = b;
    s.cnt    = 32'(bidx);
    exp_q.push_back(s);
    miso_q.push_back((bidx == 1) ? 8'h00 : bus.data_in);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], last_coincident && (i == 0));
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) clk_bit(b[7-i], 1'b0);
  endtask

  initial begin
    bus.spi_sck    = 1'b0;
    bus.spi_mosi   = 1'b0;
    bus.spi_ssel_n = 1'b1;
    bus.data_in    = 8'hA5;
    #1 rst = 1'b1;
    tick(3);
    probe_all_zero();
    tick(2);
    rst = 1'b0;
    tick(5);

    // SCK toggling with SSEL high must be ignored.
    for (int i = 0; i < 3; i++) clk_bit(1'b1, 1'b0);
    tick(4);
    probe(S_BIT, 32'd0);
    probe(S_ACT, 32'd0);

    // Command F0, then a parameter byte during which MISO returns A5.
    bus.data_in = 8'hA5;
    frame_begin();
    probe(S_ACT, 32'd1);
    probe(S_BYTE, 32'd0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h00, 1'b0);
    frame_end();

    // Command plus three parameters.
    bus.data_in = 8'h3C;
    frame_begin();
    send_byte(8'h10, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    frame_end();
    probe(S_CMD_DAT, 32'h10);
    probe(S_PAR_DAT, 32'h56);
    probe(S_BYTE, 32'd4);
    probe(S_BIT, 32'd0);

    // SSEL rises after 5 bits of byte 2: partial byte dropped.
    bus.data_in = 8'hA5;
    frame_begin();
    send_byte(8'h41, 1'b0);
    send_bits(8'hE7, 5);
    tick(2);
    probe(S_BIT, 32'd5);
    probe(S_BYTE, 32'd1);
    frame_end();
    probe(S_BIT, 32'd0);
    probe(S_BYTE, 32'd1);
    probe(S_ACT, 32'd0);
    probe(S_PAR_DAT, 32'h56);
    frame_begin();
    probe(S_BYTE, 32'd0);
    send_byte(8'h99, 1'b0);
    frame_end();

    // 8th SCK rise of a parameter coincides with SSEL rise.
    frame_begin();
    send_byte(8'h20, 1'b0);
    send_byte(8'h77, 1'b1);
    tick(2 * HALF);
    in_frame = 1'b0;
    probe(S_ACT, 32'd0);
    probe(S_BIT, 32'd0);
    probe(S_BYTE, 32'd2);
    probe(S_PAR_DAT, 32'h77);

    // Reset in the middle of a parameter byte.
    frame_begin();
    send_byte(8'h5A, 1'b0);
    send_bits(8'hFF, 4);
    tick(2);
    rst            = 1'b1;
    bus.spi_ssel_n = 1'b1;
    in_frame       = 1'b0;
    probe_all_zero();
    tick(3);
    rst = 1'b0;
    tick(6);
    frame_begin();
    send_byte(8'hC3, 1'b0);
    send_byte(8'h11, 1'b0);
    frame_end();

`ifdef MCU_SPI_TIMEOUT_EN
    // Stall SCK mid-byte past the timeout.
    frame_begin();
    send_byte(8'h33, 1'b0);
    send_bits(8'hFF, 3);
    tick(120);
    probe(S_ERR, 32'd1);
    probe(S_BIT, 32'd0);
    frame_end();
    probe(S_ERR, 32'd1);
    frame_begin();
    probe(S_ERR, 32'd0);
    send_byte(8'h44, 1'b0);
    frame_end();
`endif

    tick(20);
    done = 1'b1;
  end

endmodule
